uart_tx_buffered: RTL and testbench
===================================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 32, meaning clk cycles per serial bit (legal range 2..1023).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning transmit buffer entries (power of two, 2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port enable, input, 1 bit: high permits the start of new frames.
REQ-006 The block SHALL have port data_in, input, 8 bits: byte to transmit.
REQ-007 The block SHALL have port write, input, 1 bit: push data_in into the FIFO when high and full low.
REQ-008 The block SHALL have port full, output, 1 bit: FIFO holds FIFO_DEPTH entries.
REQ-009 The block SHALL have port empty, output, 1 bit: FIFO holds 0 entries.
REQ-010 The block SHALL have port tx, output, 1 bit: serial line, registered, idle high.
REQ-011 The block SHALL have port busy, output, 1 bit: FSM not in IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of each frame.

Function
REQ-013 Frame format SHALL be 8N1: start bit 0, then data bits LSB first, then stop bit 1; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-015 IDLE -> START SHALL occur when enable=1 and empty=0; the head entry is popped into a shift register on that same edge.
REQ-016 START -> DATA, DATA -> STOP (after bit index 7) and STOP -> next state SHALL each occur when the baud counter reaches CLKS_PER_BIT-1.
REQ-017 The baud counter SHALL reset to 0 on every bit boundary; a 3-bit bit index SHALL advance 0..7 in DATA.
REQ-018 From STOP, when enable=1 and empty=0, the FSM SHALL go directly to START and pop the next byte, giving no idle gap between frames; otherwise it SHALL go to IDLE.
REQ-019 done SHALL be high for exactly the final cycle of each stop bit.
REQ-020 Latency: for a byte written at rising edge N into an empty FIFO with the FSM in IDLE and enable=1, tx SHALL be 0 from edge N+2.
REQ-021 A write while full=1 SHALL be ignored; FIFO contents and pointers SHALL be unchanged.
REQ-022 A write and a pop on the same edge SHALL both take effect and leave the entry count unchanged, including when the FIFO is full.
REQ-023 Deasserting enable SHALL NOT abort a frame in progress; that frame completes and the FSM then idles with tx=1.
REQ-024 Writes SHALL be accepted regardless of enable.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be derived from an occupancy count (0..FIFO_DEPTH).
REQ-026 full and empty SHALL be registered and SHALL reflect the occupancy after each edge.

Reset
REQ-027 While rst=1 at a rising edge, the block SHALL set tx=1, busy=0, done=0, empty=1, full=0, state IDLE, and clear all counters and pointers.
REQ-028 Reset SHALL take priority over write and enable on the same edge.
REQ-029 Reset during a frame SHALL abort the frame, with tx=1 from the next edge, and SHALL discard all buffered bytes.

Verification
REQ-030 Scenario: after reset, enable=1, one-cycle write of 0x17 -> tx sequence 0,1,1,1,0,1,0,0,0,1 with each bit 32 cycles; done pulses once at cycle 320 of the frame; busy then falls; tx stays 1.
REQ-031 Scenario: enable=1, write 0xA5, 0x3C, 0xFF, 0x00 on consecutive cycles -> four back-to-back frames totalling 1280 cycles with no idle gap; exactly four done pulses; empty=1 afterwards.
REQ-032 Scenario: enable=0, write 5 bytes 0x01..0x05 -> full=1 after the 4th write; the 5th is dropped; tx stays 1; then enable=1 -> exactly 0x01..0x04 are sent.
REQ-033 Scenario: FIFO full and transmitting; write 0x55 on the pop edge -> write accepted, full stays 1, and 0x55 is transmitted last.
REQ-034 Scenario: rst=1 for one cycle at cycle 150 of a frame with 2 bytes queued -> tx=1 next cycle, empty=1, busy=0, and no done pulse follows.
REQ-035 Scenario: enable dropped mid-frame of 0x81 -> frame completes correctly (0,1,0,0,0,0,0,0,1,1), queued bytes are held, and transmission resumes only after enable returns to 1.

Source files
------------

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_buffered
//  Description : 8N1 UART transmitter fed by a small byte FIFO. Frames are
//                sent back to back with no idle gap while the FIFO holds
//                data and enable is high; a frame in progress always
//                completes once started (only reset aborts it).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] data_in,
    input  logic       write,
    output logic       full,
    output logic       empty,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_baud_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w:0]   c_occ_full  = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]   c_occ_one   = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);

    // Explicitly encoded, 2-bit wide state machine
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;

    logic [7:0]           r_mem [0:FIFO_DEPTH-1];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_occ;
    logic [c_ptr_w:0]     w_occ_next;
    logic                 r_full;
    logic                 r_empty;

    logic [c_cnt_w-1:0]   r_baud;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_tx;
    logic                 r_done;

    logic                 w_bit_end;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_tx_next;

    // ------------------------------------------------------------------------
    // FIFO control: a push is allowed when full only if a pop frees the slot
    // on the same edge, so the occupancy simply stays put in that case.
    // ------------------------------------------------------------------------
    assign w_push    = write && (!r_full || w_pop);
    assign w_bit_end = (r_baud == c_baud_last);

    assign w_occ_next = (w_push && !w_pop) ? (r_occ + c_occ_one) :
                        (!w_push && w_pop) ? (r_occ - c_occ_one) :
                                             r_occ;

    // Storage array: write-only port, no reset needed for the data itself
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy and the registered full/empty flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_occ   <= w_occ_next;
            r_full  <= (w_occ_next == c_occ_full);
            r_empty <= (w_occ_next == '0);
        end
    end

    // ------------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------------

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, pop request and the line level for the current bit
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            IDLE: begin
                if (enable && !r_empty) begin
                    w_state_next = START;
                    w_pop        = 1'b1;
                end
            end
            START: begin
                w_tx_next = 1'b0;
                if (w_bit_end) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                w_tx_next = r_shift[0];
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                w_tx_next = 1'b1;
                if (w_bit_end) begin
                    // Chain straight into the next frame when data is waiting
                    if (enable && !r_empty) begin
                        w_state_next = START;
                        w_pop        = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Baud counter, bit index and shift register; loading restarts timing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
        end else if (r_state == IDLE) begin
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
        end else if (w_bit_end) begin
            r_baud <= '0;
            if (r_state == DATA) begin
                r_shift   <= {1'b0, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end else begin
            r_baud <= r_baud + c_baud_one;
        end
    end

    // Registered line and end-of-frame pulse; both trail the FSM by one
    // cycle so done lines up with the last cycle of the stop bit on tx.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx   <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_tx   <= w_tx_next;
            r_done <= (r_state == STOP) && w_bit_end;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tx    = r_tx;
    assign done  = r_done;
    assign busy  = (r_state != IDLE);
    assign full  = r_full;
    assign empty = r_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_buffered
//  Description : Scoreboard bench for uart_tx_buffered. A frame-level
//                reference model predicts FIFO occupancy, busy, done and
//                which byte starts on which cycle; a line monitor decodes
//                tx and compares each frame against the scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

    localparam int CPB   = 32;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       enable  = 1'b0;
    logic       write   = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       full;
    logic       empty;
    logic       tx;
    logic       busy;
    logic       done;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .data_in (data_in),
        .write   (write),
        .full    (full),
        .empty   (empty),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    initial begin : clock_gen
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] data;
        int         start_cyc;
    } exp_t;

    exp_t       sb[$];       // frames the line must carry, in order
    logic [7:0] mq[$];       // model of the buffered bytes
    int         cyc        = 0;
    int         busy_left  = 0;
    int         rst_events = 0;
    bit         checks_on  = 1'b0;
    bit         exp_done   = 1'b0;
    int         done_seen  = 0;
    int         checks     = 0;
    int         errors     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Frame-level reference: a frame occupies the transmitter for FRAME
    // cycles after the byte leaves the buffer; the next byte may leave on
    // the cycle the previous frame ends.
    initial begin : ref_model
        bit   pop_now;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                mq.delete();
                sb.delete();
                busy_left = 0;
                exp_done  = 1'b0;
                rst_events++;
                checks_on = 1'b1;
            end else begin
                pop_now  = enable && (mq.size() > 0) && (busy_left <= 1);
                exp_done = (busy_left == 1);
                if (pop_now) begin
                    e.data      = mq.pop_front();
                    e.start_cyc = cyc + 1;
                    sb.push_back(e);
                    busy_left = FRAME;
                end else if (busy_left > 0) begin
                    busy_left--;
                end
                if (write && (mq.size() < DEPTH)) begin
                    mq.push_back(data_in);
                end
            end
        end
    end

    // Per-cycle status comparison against the model
    initial begin : cycle_checker
        forever begin
            @(negedge clk);
            if (checks_on) begin
                check("full",  32'(full),  32'(mq.size() == DEPTH));
                check("empty", 32'(empty), 32'(mq.size() == 0));
                check("busy",  32'(busy),  32'(busy_left > 0));
                check("done",  32'(done),  32'(exp_done));
                if (done === 1'b1) done_seen++;
            end
        end
    end

    // Line monitor: decodes 8N1 frames by mid-bit sampling
    initial begin : tx_monitor
        int         t;
        int         idx;
        int         seen_rst;
        bit         in_frame;
        bit         have_exp;
        logic [7:0] rx;
        exp_t       e;
        t = 0; idx = 0; seen_rst = 0; in_frame = 1'b0; have_exp = 1'b0; rx = 8'd0;
        e.data = 8'd0; e.start_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst_events != seen_rst) begin
                seen_rst = rst_events;
                in_frame = 1'b0;
            end
            if (checks_on) begin
                if (!in_frame) begin
                    if (tx !== 1'b1) begin
                        in_frame = 1'b1;
                        t        = 0;
                        rx       = 8'd0;
                        if (sb.size() == 0) begin
                            have_exp = 1'b0;
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame actual=start_at_%0d required=idle_line", cyc);
                        end else begin
                            have_exp = 1'b1;
                            e = sb.pop_front();
                            check("frame_start_cycle", 32'(cyc), 32'(e.start_cyc));
                        end
                    end
                end else begin
                    t++;
                end
                if (in_frame && ((t % CPB) == (CPB / 2))) begin
                    idx = t / CPB;
                    if (idx == 0) begin
                        check("start_bit", 32'(tx), 32'd0);
                    end else if (idx <= 8) begin
                        rx[idx-1] = tx;
                    end else begin
                        check("stop_bit", 32'(tx), 32'd1);
                        if (have_exp) check("rx_byte", 32'(rx), 32'(e.data));
                        in_frame = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wr(input logic [7:0] d);
        @(negedge clk);
        write   = 1'b1;
        data_in = d;
    endtask

    task automatic wr_end();
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic wait_quiet(input int max_cycles);
        int n;
        n = 0;
        while (!((mq.size() == 0) && (busy_left == 0)) && (n < max_cycles)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= max_cycles) begin
            errors++;
            $display("FAIL wait_quiet actual=timeout_after_%0d required=drained", n);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin : stimulus
        int k;
        int n;

        // Reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_tx",    32'(tx),    32'd1);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full",  32'(full),  32'd0);
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_done",  32'(done),  32'd0);

        // Single byte 0x17
        enable = 1'b1;
        k = done_seen;
        wr(8'h17);
        wr_end();
        wait_quiet(4 * FRAME);
        check("single_done_count", 32'(done_seen - k), 32'd1);
        check("single_tx_idle",    32'(tx),   32'd1);
        check("single_busy_low",   32'(busy), 32'd0);

        // Four back-to-back frames
        k = done_seen;
        wr(8'hA5); wr(8'h3C); wr(8'hFF); wr(8'h00);
        wr_end();
        wait_quiet(8 * FRAME);
        check("b2b_done_count", 32'(done_seen - k), 32'd4);
        check("b2b_empty",      32'(empty), 32'd1);

        // Fill with enable low; fifth write dropped
        enable = 1'b0;
        wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04); wr(8'h05);
        wr_end();
        check("fill_full", 32'(full), 32'd1);
        repeat (50) @(negedge clk);
        check("fill_tx_idle", 32'(tx),   32'd1);
        check("fill_busy",    32'(busy), 32'd0);
        k = done_seen;
        enable = 1'b1;
        wait_quiet(8 * FRAME);
        check("fill_done_count", 32'(done_seen - k), 32'd4);

        // Write on the pop edge while full and transmitting
        k = done_seen;
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44); wr(8'h66);
        wr_end();
        check("pw_full_before", 32'(full), 32'd1);
        n = 0;
        while ((busy_left != 1) && (n < 2 * FRAME)) begin
            @(negedge clk);
            n++;
        end
        check("pw_reach_pop_edge", 32'(n < 2 * FRAME), 32'd1);
        write   = 1'b1;
        data_in = 8'h55;
        @(negedge clk);
        write = 1'b0;
        check("pw_full_after", 32'(full), 32'd1);
        wait_quiet(10 * FRAME);
        check("pw_done_count", 32'(done_seen - k), 32'd6);

        // Reset in the middle of a frame with bytes queued
        wr(8'hAA); wr(8'hBB); wr(8'hCC);
        wr_end();
        repeat (150) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx",    32'(tx),    32'd1);
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_busy",  32'(busy),  32'd0);
        k = done_seen;
        repeat (2 * FRAME) @(negedge clk);
        check("midrst_no_done", 32'(done_seen - k), 32'd0);
        check("midrst_tx_idle", 32'(tx), 32'd1);

        // Enable dropped mid-frame
        k = done_seen;
        wr(8'h81); wr(8'h42);
        wr_end();
        repeat (100) @(negedge clk);
        enable = 1'b0;
        repeat (FRAME + 200) @(negedge clk);
        check("endrop_busy",  32'(busy),  32'd0);
        check("endrop_tx",    32'(tx),    32'd1);
        check("endrop_held",  32'(empty), 32'd0);
        check("endrop_done1", 32'(done_seen - k), 32'd1);
        enable = 1'b1;
        wait_quiet(4 * FRAME);
        check("endrop_done2", 32'(done_seen - k), 32'd2);
        check("endrop_empty", 32'(empty), 32'd1);

        // Randomised traffic: writes (including while full), enable toggles, rare resets
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            write   = ($urandom_range(0, 3) == 0);
            data_in = 8'($urandom);
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            rst = ($urandom_range(0, 3999) == 0);
        end
        @(negedge clk);
        write  = 1'b0;
        rst    = 1'b0;
        enable = 1'b1;
        wait_quiet((DEPTH + 3) * FRAME);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        check("final_empty",    32'(empty), 32'd1);
        check("final_tx",       32'(tx),    32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
